// File: rtl/q01_tt_scanner.sv
// Truth-table scanner: walks index {a,b,c,d} through 0..15, holds each vector
// SETTLE cycles, captures s per index, then reports popcount and golden match.
module q01_tt_scanner #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'hAC3C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  ones,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  ones_q, ones_d;
  logic        match_q, match_d;

  logic [15:0] tt_smp;
  logic [4:0]  pop;

  always_comb begin
    tt_smp         = tt_q;
    tt_smp[idx_q]  = s;
    pop            = '0;
    for (int i = 0; i < 16; i++) pop = pop + 5'(tt_smp[i]);

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    match_d = match_q;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = SETTLE_C;
          tt_d    = '0;
          ones_d  = '0;
          match_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // start is deliberately not looked at here: no mid-scan restart
        if (cnt_q == 4'd1) begin
          tt_d = tt_smp;
          if (idx_q == 4'hF) begin
            state_d = FIN;
            ones_d  = pop;
            match_d = (tt_smp == EXPECT);
          end else begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_C;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      match_q <= match_d;
    end
  end

  assign {a, b, c, d} = idx_q;
  assign busy  = (state_q == SCAN);
  assign done  = (state_q == FIN);
  assign tt    = tt_q;
  assign ones  = ones_q;
  assign match = match_q;

endmodule

// File: tb/tb_q01_tt_scanner.sv
// Scoreboard bench: stimulus pushes expected scan results, per-instance
// monitors pop and compare whenever done is seen.
module tb_q01_tt_scanner;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        match;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  int   mode = 0;
  int   cyc = 0;
  int   n_vec = 0, n_bad = 0;

  logic a1, b1, c1, d1, busy1, done1, match1, s1;
  logic a3, b3, c3, d3, busy3, done3, match3, s3;
  logic [15:0] tt1, tt3;
  logic [4:0]  ones1, ones3;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic sfun(input int m, input logic a, b, c, d);
    case (m)
      0:       return (~b & c) | (~a & b & ~c) | (a & b & d);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a;
    endcase
  endfunction

  assign s1 = sfun(mode, a1, b1, c1, d1);
  assign s3 = sfun(mode, a3, b3, c3, d3);

  q01_tt_scanner #(.SETTLE(1), .EXPECT(16'hAC3C)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s(s1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .tt(tt1), .ones(ones1), .match(match1));

  q01_tt_scanner #(.SETTLE(3), .EXPECT(16'hAC3C)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s(s3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .tt(tt3), .ones(ones3), .match(match3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 32'(done1), 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 tt", 32'(tt1), 32'(e.tt));
        chk("dut1 ones", 32'(ones1), 32'(e.ones));
        chk("dut1 match", 32'(match1), 32'(e.match));
        chk("dut1 done cycle", 32'(cyc), 32'(e.cyc));
        chk("dut1 busy at done", 32'(busy1), 32'd0);
        chk("dut1 abcd at done", 32'({a1, b1, c1, d1}), 32'hF);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) chk("dut3 unexpected done", 32'(done3), 32'd0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("dut3 tt", 32'(tt3), 32'(e.tt));
        chk("dut3 ones", 32'(ones3), 32'(e.ones));
        chk("dut3 match", 32'(match3), 32'(e.match));
        chk("dut3 done cycle", 32'(cyc), 32'(e.cyc));
        chk("dut3 busy at done", 32'(busy3), 32'd0);
      end
    end
  end

  // Accept a scan on the next edge and queue its expected result
  task automatic scan(input int w, input logic [15:0] ett, input logic [4:0] eones, input logic em);
    exp_t e;
    @(negedge clk);
    if (w == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    e.tt = ett; e.ones = eones; e.match = em;
    e.cyc = cyc + ((w == 1) ? 16 : 48);
    if (w == 1) q1.push_back(e); else q3.push_back(e);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_idle(input int w);
    logic bz;
    bz = 1'b1;
    for (int i = 0; i < 300 && bz; i++) begin
      @(negedge clk);
      bz = (w == 1) ? busy1 : busy3;
    end
    if (bz) chk("scan timeout", 32'(bz), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, " abcd"}, 32'({a1, b1, c1, d1}), 32'd0);
    chk({tag, " busy"}, 32'(busy1), 32'd0);
    chk({tag, " done"}, 32'(done1), 32'd0);
    chk({tag, " tt"}, 32'(tt1), 32'd0);
    chk({tag, " ones"}, 32'(ones1), 32'd0);
    chk({tag, " match"}, 32'(match1), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic hit;
    repeat (2) @(posedge clk);
    #1;
    chk_zero1("reset dut1");
    chk("reset dut3 abcd", 32'({a3, b3, c3, d3}), 32'd0);
    chk("reset dut3 busy", 32'(busy3), 32'd0);
    chk("reset dut3 tt", 32'(tt3), 32'd0);
    chk("reset dut3 ones", 32'(ones3), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // golden function, SETTLE=1
    mode = 0;
    scan(1, 16'hAC3C, 5'd8, 1'b1);
    chk("dut1 busy after accept", 32'(busy1), 32'd1);
    wait_idle(1);

    // golden function, SETTLE=3: every vector held three cycles
    scan(3, 16'hAC3C, 5'd8, 1'b1);
    for (int j = 0; j < 48; j++) begin
      @(negedge clk);
      chk("dut3 held index", 32'({a3, b3, c3, d3}), 32'(j / 3));
      chk("dut3 busy in scan", 32'(busy3), 32'd1);
    end
    wait_idle(3);

    mode = 1;
    scan(1, 16'h0000, 5'd0, 1'b0);
    wait_idle(1);
    mode = 2;
    scan(1, 16'hFFFF, 5'd16, 1'b0);
    wait_idle(1);

    // start held high: one scan, then a second accepted in the FIN cycle
    mode = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1;
    e.tt = 16'hAC3C; e.ones = 5'd8; e.match = 1'b1;
    e.cyc = cyc + 16; q1.push_back(e);
    e.cyc = cyc + 33; q1.push_back(e);
    repeat (17) @(posedge clk);
    #1 start1 = 1'b0;
    chk("dut1 busy on back-to-back", 32'(busy1), 32'd1);
    chk("dut1 index restarted", 32'({a1, b1, c1, d1}), 32'd0);
    wait_idle(1);

    // reset mid-scan at vector 7, with start high in the same cycle
    scan(1, 16'hAC3C, 5'd8, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = ({a1, b1, c1, d1} == 4'd7);
    end
    chk("reached vector 7", 32'(hit), 32'd1);
    rst_n = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    void'(q1.pop_back());
    chk_zero1("mid-scan reset");
    @(negedge clk);
    rst_n = 1'b1;
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle after reset busy", 32'(busy1), 32'd0);
    scan(1, 16'hAC3C, 5'd8, 1'b1);
    wait_idle(1);

    mode = 3;
    scan(1, 16'hFF00, 5'd8, 1'b0);
    wait_idle(1);

    repeat (3) @(negedge clk);
    chk("dut1 results pending", 32'(q1.size()), 32'd0);
    chk("dut3 results pending", 32'(q3.size()), 32'd0);
    chk("dut1 tt held", 32'(tt1), 32'hFF00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
